conv_window_sched: RTL and testbench

// - Sequences the CNN engine's pixel-shift datapath (DFF pipeline registers and line buffers) for one frame.
// - Accepts a raster-order pixel stream and drives the bank shift enable.
// - Tracks row/col position and flags each cycle the KxK window held in the bank is a valid conv output.
// - Sits between the input stream source and the MAC array. Holds off input while an emitted window is unconsumed.

---
 rtl/conv_window_sched.sv | 196 +++++++++++++++++++
 tb/tb_conv_window_sched.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_sched.sv
// Frame sequencer for the CNN pixel-shift bank: paces the raster stream and flags valid KxK windows.
// Optional stride-2 support is built when WIN_STRIDE_EN is defined; otherwise stride is fixed at 1.
module conv_window_sched #(
  parameter int ColBits = 7,
  parameter int RowBits = 7,
  parameter int CntBits = 14
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [ColBits-1:0] cfg_width,
  input  logic [RowBits-1:0] cfg_height,
  input  logic               cfg_ksel,
  input  logic               cfg_stride,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               shift_en,
  output logic               win_valid,
  input  logic               out_ready,
  output logic [RowBits-1:0] out_row,
  output logic [ColBits-1:0] out_col,
  output logic [CntBits-1:0] win_cnt,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t             state_r;
  logic [ColBits-1:0] width_r;
  logic [RowBits-1:0] height_r;
  logic               k5_r;
  logic [ColBits-1:0] col_r;
  logic [RowBits-1:0] row_r;
  logic               win_valid_r;
  logic [RowBits-1:0] out_row_r;
  logic [ColBits-1:0] out_col_r;
  logic [CntBits-1:0] win_cnt_r;
  logic               busy_r;
  logic               done_r;
  logic               cfg_err_r;

  logic               in_ready_s;
  logic               xfer_s;
  logic               consume_s;
  logic               cfg_ok_s;
  logic               last_col_s;
  logic               last_pix_s;
  logic [ColBits-1:0] kcol_s;
  logic [RowBits-1:0] krow_s;
  logic [ColBits-1:0] col_off_s;
  logic [RowBits-1:0] row_off_s;
  logic               on_grid_s;
  logic               cand_s;
  logic [RowBits-1:0] win_row_s;
  logic [ColBits-1:0] win_col_s;

`ifdef WIN_STRIDE_EN
  logic stride_r;

  // Stride-2 windows sit on even offsets from the first full window.
  function automatic logic on_stride_grid(input logic [RowBits-1:0] r, input logic [ColBits-1:0] c);
    return (r[0] == 1'b0) && (c[0] == 1'b0);
  endfunction
`else
  logic stride_unused_s;
  assign stride_unused_s = cfg_stride;
`endif

  assign cfg_ok_s   = (cfg_width  >= (cfg_ksel ? ColBits'(5) : ColBits'(3))) &&
                      (cfg_height >= (cfg_ksel ? RowBits'(5) : RowBits'(3)));
  assign kcol_s     = k5_r ? ColBits'(4) : ColBits'(2);
  assign krow_s     = k5_r ? RowBits'(4) : RowBits'(2);
  assign col_off_s  = col_r - kcol_s;
  assign row_off_s  = row_r - krow_s;
  assign last_col_s = (col_r == width_r - ColBits'(1));
  assign last_pix_s = last_col_s && (row_r == height_r - RowBits'(1));

  assign in_ready_s = (state_r == S_RUN) && !(win_valid_r && !out_ready);
  assign xfer_s     = in_valid && in_ready_s;
  assign consume_s  = win_valid_r && out_ready;
  assign cand_s     = xfer_s && (row_r >= krow_s) && (col_r >= kcol_s) && on_grid_s;

  // Stride-dependent window placement and output-map coordinates.
  always_comb begin
    on_grid_s = 1'b1;
    win_row_s = row_off_s;
    win_col_s = col_off_s;
`ifdef WIN_STRIDE_EN
    if (stride_r) begin
      on_grid_s = on_stride_grid(row_off_s, col_off_s);
      win_row_s = row_off_s >> 1;
      win_col_s = col_off_s >> 1;
    end else begin
      on_grid_s = 1'b1;
      win_row_s = row_off_s;
      win_col_s = col_off_s;
    end
`endif
  end

  // Frame FSM, raster position counters and the pending-window register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= S_IDLE;
      width_r     <= '0;
      height_r    <= '0;
      k5_r        <= 1'b0;
`ifdef WIN_STRIDE_EN
      stride_r    <= 1'b0;
`endif
      col_r       <= '0;
      row_r       <= '0;
      win_valid_r <= 1'b0;
      out_row_r   <= '0;
      out_col_r   <= '0;
      win_cnt_r   <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      if (cand_s) begin
        win_valid_r <= 1'b1;
        out_row_r   <= win_row_s;
        out_col_r   <= win_col_s;
      end else if (consume_s) begin
        win_valid_r <= 1'b0;
      end
      if (consume_s) begin
        win_cnt_r <= win_cnt_r + CntBits'(1);
      end

      case (state_r)
        S_IDLE: begin
          if (start && cfg_ok_s) begin
            width_r   <= cfg_width;
            height_r  <= cfg_height;
            k5_r      <= cfg_ksel;
`ifdef WIN_STRIDE_EN
            stride_r  <= cfg_stride;
`endif
            col_r     <= '0;
            row_r     <= '0;
            win_cnt_r <= '0;
            cfg_err_r <= 1'b0;
            busy_r    <= 1'b1;
            state_r   <= S_RUN;
          end else if (start) begin
            cfg_err_r <= 1'b1;
          end
        end
        S_RUN: begin
          if (xfer_s) begin
            if (last_col_s) begin
              col_r <= '0;
              row_r <= row_r + RowBits'(1);
            end else begin
              col_r <= col_r + ColBits'(1);
            end
            if (last_pix_s) begin
              state_r <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (!win_valid_r || consume_s) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= S_DONE;
          end
        end
        S_DONE: begin
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign shift_en  = xfer_s;
  assign win_valid = win_valid_r;
  assign out_row   = out_row_r;
  assign out_col   = out_col_r;
  assign win_cnt   = win_cnt_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench for conv_window_sched: frame window sequences, back-pressure, config errors, resets.
module tb_conv_window_sched;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [6:0]  cfg_width;
  logic [6:0]  cfg_height;
  logic        cfg_ksel;
  logic        cfg_stride;
  logic        in_valid;
  logic        in_ready;
  logic        shift_en;
  logic        win_valid;
  logic        out_ready;
  logic [6:0]  out_row;
  logic [6:0]  out_col;
  logic [13:0] win_cnt;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int n_vec = 0;
  int n_err = 0;

  logic mon_clr = 1'b0;
  int   xfer_cnt;
  int   done_cnt;
  int   first_wx;
  int   qr[$];
  int   qc[$];
  int   qx[$];

  conv_window_sched dut (
    .CLK(CLK), .RST(RST), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_ksel(cfg_ksel), .cfg_stride(cfg_stride), .in_valid(in_valid), .in_ready(in_ready),
    .shift_en(shift_en), .win_valid(win_valid), .out_ready(out_ready), .out_row(out_row),
    .out_col(out_col), .win_cnt(win_cnt), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 CLK = ~CLK;

  // Record transfers, done pulses and consumed windows between clock edges.
  always @(negedge CLK) begin
    if (mon_clr) begin
      xfer_cnt <= 0;
      done_cnt <= 0;
      first_wx <= -1;
      qr.delete();
      qc.delete();
      qx.delete();
    end else begin
      if (shift_en) xfer_cnt <= xfer_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (win_valid && first_wx < 0) first_wx <= xfer_cnt;
      if (win_valid && out_ready) begin
        qr.push_back(int'(out_row));
        qc.push_back(int'(out_col));
        qx.push_back(xfer_cnt);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
  endtask

  task automatic start_frame(input int w, input int h, input logic ks, input logic st);
    cfg_width  = 7'(w);
    cfg_height = 7'(h);
    cfg_ksel   = ks;
    cfg_stride = st;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic run_to_done(input string tag);
    in_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      step();
      if (done_cnt != 0) break;
    end
    in_valid = 1'b0;
    check_eq({tag, "_done_seen"}, done_cnt, 1);
  endtask

  task automatic check_frame(input string tag, input int nwin, input int nxfer);
    step();
    step();
    check_eq({tag, "_done_pulses"}, done_cnt, 1);
    check_eq({tag, "_nwin"}, qr.size(), nwin);
    check_eq({tag, "_xfers"}, xfer_cnt, nxfer);
    check_eq({tag, "_win_cnt"}, win_cnt, nwin);
    check_eq({tag, "_busy"}, busy, 0);
  endtask

  // 5x5 frame, 3x3 kernel, stride 1: windows (0,0)..(2,2) after transfers 13,14,15,18,...
  task automatic check_5x5_k3(input string tag);
    for (int i = 0; i < 9; i++) begin
      if (i < qr.size()) begin
        check_eq({tag, "_row"}, qr[i], i / 3);
        check_eq({tag, "_col"}, qc[i], i % 3);
        check_eq({tag, "_xidx"}, qx[i], (i / 3 + 2) * 5 + (i % 3 + 2) + 1);
      end
    end
  endtask

  initial begin
    int er4[4];
    int ec4[4];
    int ex4[4];
    RST = 1'b1; start = 1'b0; cfg_width = 7'd0; cfg_height = 7'd0;
    cfg_ksel = 1'b0; cfg_stride = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    clr_mon();
    step();
    RST = 1'b0;
    #1;
    check_eq("rst_win_valid", win_valid, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_cfg_err", cfg_err, 0);
    check_eq("rst_win_cnt", win_cnt, 0);
    check_eq("rst_out_row", out_row, 0);
    check_eq("rst_out_col", out_col, 0);

    // Basic 5x5, K=3, stride 1.
    clr_mon();
    start_frame(5, 5, 1'b0, 1'b0);
    check_eq("t1_busy", busy, 1);
    run_to_done("t1");
    check_frame("t1", 9, 25);
    check_eq("t1_first_win", first_wx, 13);
    check_5x5_k3("t1");

    // Stride request: honoured only when the stride feature is built.
    clr_mon();
    start_frame(5, 5, 1'b0, 1'b1);
    run_to_done("t2");
`ifdef WIN_STRIDE_EN
    check_frame("t2", 4, 25);
    er4 = '{0, 0, 1, 1};
    ec4 = '{0, 1, 0, 1};
    ex4 = '{13, 15, 23, 25};
    for (int i = 0; i < 4; i++) begin
      if (i < qr.size()) begin
        check_eq("t2_row", qr[i], er4[i]);
        check_eq("t2_col", qc[i], ec4[i]);
        check_eq("t2_xidx", qx[i], ex4[i]);
      end
    end
`else
    check_frame("t2", 9, 25);
    check_5x5_k3("t2");
`endif

    // 6x6, K=5 with the first window held by the consumer.
    clr_mon();
    out_ready = 1'b0;
    start_frame(6, 6, 1'b1, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (first_wx >= 0) break;
    end
    #1;
    check_eq("t3_first_win", first_wx, 29);
    check_eq("t3_stall_win_valid", win_valid, 1);
    check_eq("t3_stall_in_ready", in_ready, 0);
    check_eq("t3_stall_shift_en", shift_en, 0);
    check_eq("t3_stall_row", out_row, 0);
    check_eq("t3_stall_col", out_col, 0);
    repeat (3) step();
    check_eq("t3_hold_win_valid", win_valid, 1);
    check_eq("t3_hold_row", out_row, 0);
    check_eq("t3_hold_col", out_col, 0);
    check_eq("t3_hold_xfers", xfer_cnt, 29);
    out_ready = 1'b1;
    run_to_done("t3");
    check_frame("t3", 4, 36);
    er4 = '{0, 0, 1, 1};
    ec4 = '{0, 1, 0, 1};
    ex4 = '{29, 30, 35, 36};
    for (int i = 0; i < 4; i++) begin
      if (i < qr.size()) begin
        check_eq("t3_row", qr[i], er4[i]);
        check_eq("t3_col", qc[i], ec4[i]);
        check_eq("t3_xidx", qx[i], ex4[i]);
      end
    end

    // Rejected configurations, then recovery with a legal one.
    clr_mon();
    start_frame(4, 6, 1'b1, 1'b0);
    #1;
    check_eq("t4_err_w", cfg_err, 1);
    check_eq("t4_err_busy", busy, 0);
    check_eq("t4_err_in_ready", in_ready, 0);
    start_frame(7, 2, 1'b0, 1'b0);
    check_eq("t4_err_h", cfg_err, 1);
    check_eq("t4_err_h_busy", busy, 0);
    start_frame(5, 5, 1'b0, 1'b0);
    check_eq("t4_ok_cfg_err", cfg_err, 0);
    check_eq("t4_ok_busy", busy, 1);
    run_to_done("t4");
    check_frame("t4", 9, 25);

    // Minimum legal frame: W=H=K gives a single window.
    clr_mon();
    start_frame(3, 3, 1'b0, 1'b0);
    run_to_done("t5");
    check_frame("t5", 1, 9);
    if (qr.size() > 0) begin
      check_eq("t5_row", qr[0], 0);
      check_eq("t5_col", qc[0], 0);
      check_eq("t5_xidx", qx[0], 9);
    end

    // Reset after 10 transfers, then a fresh frame.
    clr_mon();
    start_frame(5, 5, 1'b0, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (xfer_cnt >= 10) break;
    end
    check_eq("t6_xfers_before_rst", xfer_cnt, 10);
    in_valid = 1'b0;
    RST = 1'b1;
    step();
    RST = 1'b0;
    #1;
    check_eq("t6_busy", busy, 0);
    check_eq("t6_win_valid", win_valid, 0);
    check_eq("t6_in_ready", in_ready, 0);
    check_eq("t6_done", done, 0);
    check_eq("t6_win_cnt", win_cnt, 0);
    check_eq("t6_out_row", out_row, 0);
    check_eq("t6_out_col", out_col, 0);
    repeat (4) step();
    check_eq("t6_no_done", done_cnt, 0);
    clr_mon();
    start_frame(5, 5, 1'b0, 1'b0);
    run_to_done("t6b");
    check_frame("t6b", 9, 25);
    check_5x5_k3("t6b");

    // Start pulsed mid-frame with another config is ignored.
    clr_mon();
    start_frame(5, 5, 1'b0, 1'b0);
    in_valid = 1'b1;
    repeat (5) step();
    start_frame(6, 6, 1'b1, 1'b0);
    check_eq("t7_cfg_err", cfg_err, 0);
    run_to_done("t7");
    check_frame("t7", 9, 25);
    check_5x5_k3("t7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
